sad_accum: RTL

Parametrised sum-of-absolute-differences accumulator for the SAD datapath. Each accepted beat carries LANES pixel pairs. The block sums |a−b| across all lanes, then accumulates that beat sum over a fixed block of BLOCK_BEATS beats. Each completed block SAD is presented on a single-entry valid/ready output register. It replaces the plain enable-loaded sum register and adds lane parallelism, block framing, backpressure and overflow handling.

---
 rtl/sad_accum.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sad_accum.sv
`default_nettype none
// ============================================================================
// Module   : sad_accum
// Purpose  : Sum-of-absolute-differences accumulator. Each accepted beat
//            carries LANES unsigned pixel pairs; |a-b| is summed across the
//            lanes and accumulated over BLOCK_BEATS beats. The completed block
//            SAD is held on a single-entry valid/ready output register.
// Macro    : SAD_ACCUM_SAT_EN - when defined the accumulator saturates at
//            2^SUM_W-1 and ovf flags the saturated result; when undefined the
//            accumulator wraps and ovf is tied to 0.
// Ports    : clk, rst (sync, active-high), clr (sync abort of partial block)
//            in_valid/in_ready, a/b (LANES*DATA_W packed, lane i at
//            [i*DATA_W +: DATA_W]), out_valid/out_ready, sum, ovf.
// Revision : 1.0 - initial release
// ============================================================================
module sad_accum #(
    parameter int DATA_W      = 8,
    parameter int LANES       = 4,
    parameter int SUM_W       = 32,
    parameter int BLOCK_BEATS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] a,
    input  logic [LANES*DATA_W-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SUM_W-1:0]        sum,
    output logic                    ovf
);

    localparam int c_BEAT_W = DATA_W + $clog2(LANES);
    localparam int c_CNT_W  = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BLOCK_BEATS - 1);

    localparam logic [0:0] c_ST_ACCUM = 1'b0;
    localparam logic [0:0] c_ST_HOLD  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0]   r_acc;
    logic [SUM_W-1:0]   r_sum;

    logic [DATA_W-1:0]   w_diff [LANES];
    logic [c_BEAT_W-1:0] w_beat_sum;
    logic [SUM_W-1:0]    w_beat_ext;
    logic [SUM_W-1:0]    w_base;
    logic [SUM_W-1:0]    w_acc_nxt;
    logic                w_accept;
    logic                w_first;
    logic                w_last;

    // Per-lane absolute difference; the larger operand is always the minuend
    // so the result fits in DATA_W bits without a sign bit.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] w_a;
            logic [DATA_W-1:0] w_b;
            assign w_a        = a[gi*DATA_W +: DATA_W];
            assign w_b        = b[gi*DATA_W +: DATA_W];
            assign w_diff[gi] = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
        end
    endgenerate

    always_comb begin
        w_beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_beat_sum = w_beat_sum + c_BEAT_W'(w_diff[i]);
        end
    end

    assign w_beat_ext = SUM_W'(w_beat_sum);

    // A held result may be replaced in the same cycle it is consumed, so the
    // first beat of the next block need not wait for a bubble.
    assign in_ready  = !clr && ((r_state == c_ST_ACCUM) || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_first   = (r_cnt == '0);
    assign w_last    = (r_cnt == c_LAST);
    // The first beat of a block loads rather than adds.
    assign w_base    = w_first ? '0 : r_acc;
    assign out_valid = (r_state == c_ST_HOLD);
    assign sum       = r_sum;

`ifdef SAD_ACCUM_SAT_EN
    logic [SUM_W:0] w_add;
    logic           w_ovf_nxt;
    logic           r_acc_ovf;
    logic           r_ovf;

    // Once clamped, any further non-zero beat carries out again, so the
    // accumulator stays at full scale for the rest of the block.
    assign w_add     = {1'b0, w_base} + {1'b0, w_beat_ext};
    assign w_acc_nxt = w_add[SUM_W] ? {SUM_W{1'b1}} : w_add[SUM_W-1:0];
    assign w_ovf_nxt = (w_first ? 1'b0 : r_acc_ovf) | w_add[SUM_W];
    assign ovf       = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_ovf <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (clr) begin
            r_acc_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc_ovf <= w_ovf_nxt;
            if (w_last) begin
                r_ovf <= w_ovf_nxt;
            end
        end
    end
`else
    assign w_acc_nxt = w_base + w_beat_ext;
    assign ovf       = 1'b0;
`endif

    // Output FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_ACCUM: begin
                if (w_accept && w_last) begin
                    w_state_nxt = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                // A last beat accepted alongside the handshake refills HOLD.
                if (out_ready && !(w_accept && w_last)) begin
                    w_state_nxt = c_ST_ACCUM;
                end
            end
            default: w_state_nxt = c_ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: counter, accumulator and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_sum <= '0;
        end else if (clr) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_nxt;
            if (w_last) begin
                r_cnt <= '0;
                r_sum <= w_acc_nxt;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
